bpsk_tx_frame_ctrl: RTL
=======================

Name: bpsk_tx_frame_ctrl

Overview:
Transmit-side frame sequencer that drives the bit input of the BPSK modem top. It accepts payload bytes over a valid/ready stream and a start/length command. It serialises preamble, sync word, length byte and payload MSB-first, holding each bit for SAMPLES_PER_BIT clocks. It then enforces an idle guard interval before reporting done.

Parameters:
SAMPLES_PER_BIT, 20, clocks each bit is held on bit_data_out; must be ≥2.
PREAMBLE_BITS, 16, alternating pattern length, first bit 1 (1,0,1,0,...).
SYNC_WORD, 8'hD3, sync pattern sent MSB-first after the preamble.
GUARD_BITS, 4, bit periods with bit_data_en low after the last frame bit.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle frame request; sampled only in IDLE
frame_len  in  8  payload byte count; latched on accepted start
byte_in  in  8  payload byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  controller accepts byte_in this cycle
bit_data_out  out  1  bit to modulator, connects to bit_data_in
bit_data_en  out  1  bit valid, connects to bit_data_in_en
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end
underrun  out  1  one-cycle pulse when a payload byte was missing at its boundary

Behaviour:
- Reset (async): all outputs 0; FSM=IDLE; bit timer, counters, byte buffer and shift register cleared. Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE → PREAMBLE → SYNC → LEN → PAYLOAD → GUARD → IDLE. With the CRC feature, CRC is inserted between PAYLOAD and GUARD.
- If frame_len==0, LEN goes directly to GUARD, or to CRC when the feature is compiled in.
- Bit timer counts 0..SAMPLES_PER_BIT-1. A new bit is presented when the timer is 0. The state/bit index advances on the timer wrap.
- Latency: start=1 in IDLE at edge N gives busy=1, bit_data_en=1 and bit_data_out=1 (first preamble bit) from cycle N+1.
- start while busy is ignored; no queueing.
- bit_data_en stays high continuously for (PREAMBLE_BITS+8+8+8*frame_len[+8])*SAMPLES_PER_BIT cycles.
- In GUARD: bit_data_en=0 and bit_data_out=0 for GUARD_BITS*SAMPLES_PER_BIT cycles. On the last GUARD cycle: done=1, and busy=0 from the next cycle.
- Byte buffer: one-entry holding register.
  - byte_ready=1 when the state is LEN or PAYLOAD, the buffer is empty, and bytes_requested < frame_len.
  - Transfer occurs on byte_valid&&byte_ready.
  - byte_ready=0 in IDLE, PREAMBLE, SYNC, CRC and GUARD.
- Payload byte boundary: the shift register loads on the wrap that starts bit 7 of a payload byte's predecessor period end, i.e. the first cycle of each payload byte.
  - If the buffer is full: move buffer to shift register and mark the buffer empty. A same-cycle accept then refills it.
  - If the buffer is empty: load 8'h00, pulse underrun for 1 cycle, and count the byte as sent; the frame continues.
- Bytes offered beyond frame_len are never accepted.
- Byte counters are 8-bit with no wrap: frame_len max 255.
- bit_data_out is registered. It must not glitch within a bit period.

Optional Feature:
- Macro BPSK_FRAME_CRC_EN.
- Defined: CRC-8 is computed over the length byte and all transmitted payload bytes, including underrun 0x00 substitutes.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR, MSB-first.
  - The CRC is sent as 8 bits in state CRC after PAYLOAD.
- Undefined: no CRC state or logic; PAYLOAD goes to GUARD.

Test Plan:
- SAMPLES_PER_BIT=4, frame_len=2, bytes 0xA5,0x3C presented early → bit stream 1010…(16), 11010011, 00000010, 10100101, 00111100. Each bit is held 4 cycles; then 16 guard cycles with en=0; done pulses once; underrun never asserts.
- frame_len=0 → preamble+sync+0x00 (32 bits, 128 cycles at SPB=4), then guard and done; byte_ready never asserts.
- frame_len=3, byte_valid withheld for the 2nd byte → the 2nd payload byte is sent as 0x00, underrun pulses exactly once at its first cycle, and the 3rd byte is still accepted and sent.
- start pulsed again mid-PAYLOAD with frame_len=9 → ignored; the frame length stays as originally latched; busy is unchanged.
- rst asserted during SYNC → all outputs 0 immediately and no done; a new start after release produces a full frame from the preamble.
- With BPSK_FRAME_CRC_EN defined, frame_len=1, byte 0x01 → CRC field 0x12 transmitted after the payload. Without the macro, guard follows the payload directly.

Source files
------------

// File: rtl/bpsk_tx_frame_ctrl_if.sv
// rtl/bpsk_tx_frame_ctrl_if.sv - signal bundle between a frame source and the BPSK transmit frame controller
//
// Purpose: groups the command, payload stream, modulator feed and status signals
// of bpsk_tx_frame_ctrl so they can be passed as one port.
// Signals:
//   start, frame_len              frame command (source -> controller)
//   byte_in, byte_valid           payload byte stream (source -> controller)
//   byte_ready                    payload stream back-pressure (controller -> source)
//   bit_data_out, bit_data_en     bit feed toward the modulator (controller -> source side)
//   busy, done, underrun          frame status (controller -> source side)
// Modports: master = frame source / testbench side, slave = the controller.
interface bpsk_tx_frame_ctrl_if;
  logic       start;
  logic [7:0] frame_len;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       bit_data_out;
  logic       bit_data_en;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output start, frame_len, byte_in, byte_valid,
    input  byte_ready, bit_data_out, bit_data_en, busy, done, underrun
  );

  modport slave (
    input  start, frame_len, byte_in, byte_valid,
    output byte_ready, bit_data_out, bit_data_en, busy, done, underrun
  );
endinterface

// File: rtl/bpsk_tx_frame_ctrl.sv
// rtl/bpsk_tx_frame_ctrl.sv - transmit frame sequencer feeding the BPSK modem bit input
//
// Purpose: on start, serialises preamble (1,0,1,0...), SYNC_WORD, the length byte
// and frame_len payload bytes MSB-first, each bit held for SAMPLES_PER_BIT clocks,
// then keeps the bit enable low for GUARD_BITS bit periods and pulses done.
// Optional feature: define BPSK_FRAME_CRC_EN to append a CRC-8 (poly 0x07, init 0,
// MSB-first) over the length byte and payload bytes after the payload.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   bpsk_tx_frame_ctrl_if.slave: start/frame_len command, byte_in/byte_valid/
//         byte_ready payload stream, bit_data_out/bit_data_en modulator feed,
//         busy/done/underrun status
module bpsk_tx_frame_ctrl #(
  parameter int         SAMPLES_PER_BIT = 20,
  parameter int         PREAMBLE_BITS   = 16,
  parameter logic [7:0] SYNC_WORD       = 8'hD3,
  parameter int         GUARD_BITS      = 4
) (
  input logic                 clk,
  input logic                 rst,
  bpsk_tx_frame_ctrl_if.slave bus
);

  localparam int TMR_W   = $clog2(SAMPLES_PER_BIT);
  localparam int IDX_MAX = (PREAMBLE_BITS > GUARD_BITS)
                         ? ((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8)
                         : ((GUARD_BITS > 8) ? GUARD_BITS : 8);
  localparam int IDX_W   = $clog2(IDX_MAX);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SAMPLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(7);
  localparam logic [IDX_W-1:0] GRD_LAST  = IDX_W'(GUARD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
`ifdef BPSK_FRAME_CRC_EN
    S_CRC,
`endif
    S_GUARD
  } state_t;

  state_t           state, state_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [7:0]       shreg, shreg_next;
  logic             bit_q, bit_next;
  logic             en_q, en_next;
  logic             underrun_q;
  logic [7:0]       len_q;
  logic [7:0]       byte_cnt;      // payload byte slots started (sent or substituted)
  logic [7:0]       req_cnt;       // payload byte slots already claimed (accepted or substituted)
  logic [7:0]       buf_q;
  logic             buf_full;
  logic             wrap;
  logic             len_latch;
  logic             pay_load;
  logic             slot_underrun;
  logic             accept;
  logic             byte_ready_c;
  logic             done_c;
  logic [7:0]       pay_byte;

`ifdef BPSK_FRAME_CRC_EN
  logic [7:0] crc_q;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`endif

  assign wrap          = (tmr == TMR_LAST);
  assign pay_byte      = buf_full ? buf_q : 8'h00;
  assign slot_underrun = pay_load & ~buf_full;
  assign accept        = byte_ready_c & bus.byte_valid;

  // An underrun slot claims a byte slot in the same cycle, so it is counted
  // before deciding whether one more byte may still be taken.
  always_comb begin
    byte_ready_c = 1'b0;
    if ((state == S_LEN || state == S_PAYLOAD) && !buf_full)
      byte_ready_c = ({1'b0, req_cnt} + {8'b0, slot_underrun}) < {1'b0, len_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Every bit-level decision is taken on the timer wrap so the registered
  // bit output only ever changes at a bit boundary.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    shreg_next = shreg;
    bit_next   = bit_q;
    en_next    = en_q;
    tmr_next   = '0;
    len_latch  = 1'b0;
    pay_load   = 1'b0;
    done_c     = 1'b0;
    if (state != S_IDLE && !wrap) tmr_next = tmr + TMR_W'(1);

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_PREAMBLE;
          idx_next   = '0;
          bit_next   = 1'b1;
          en_next    = 1'b1;
          len_latch  = 1'b1;
        end
      end

      S_PREAMBLE: begin
        if (wrap) begin
          if (idx == PRE_LAST) begin
            state_next = S_SYNC;
            idx_next   = '0;
            shreg_next = SYNC_WORD;
            bit_next   = SYNC_WORD[7];
          end else begin
            idx_next = idx + IDX_W'(1);
            bit_next = ~bit_q;
          end
        end
      end

      S_SYNC, S_LEN,
`ifdef BPSK_FRAME_CRC_EN
      S_CRC,
`endif
      S_PAYLOAD: begin
        if (wrap) begin
          if (idx != BYTE_LAST) begin
            idx_next   = idx + IDX_W'(1);
            shreg_next = {shreg[6:0], 1'b0};
            bit_next   = shreg[6];
          end else begin
            idx_next = '0;
            case (state)
              S_SYNC: begin
                state_next = S_LEN;
                shreg_next = len_q;
                bit_next   = len_q[7];
              end
              S_LEN, S_PAYLOAD: begin
                if (byte_cnt != len_q) begin
                  state_next = S_PAYLOAD;
                  pay_load   = 1'b1;
                  shreg_next = pay_byte;
                  bit_next   = pay_byte[7];
                end else begin
`ifdef BPSK_FRAME_CRC_EN
                  state_next = S_CRC;
                  shreg_next = crc_q;
                  bit_next   = crc_q[7];
`else
                  state_next = S_GUARD;
                  bit_next   = 1'b0;
                  en_next    = 1'b0;
`endif
                end
              end
              default: begin
                state_next = S_GUARD;
                bit_next   = 1'b0;
                en_next    = 1'b0;
              end
            endcase
          end
        end
      end

      S_GUARD: begin
        if (wrap) begin
          if (idx == GRD_LAST) begin
            state_next = S_IDLE;
            idx_next   = '0;
            done_c     = 1'b1;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        bit_next   = 1'b0;
        en_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr        <= '0;
      idx        <= '0;
      shreg      <= '0;
      bit_q      <= 1'b0;
      en_q       <= 1'b0;
      underrun_q <= 1'b0;
      len_q      <= '0;
      byte_cnt   <= '0;
      req_cnt    <= '0;
      buf_q      <= '0;
      buf_full   <= 1'b0;
`ifdef BPSK_FRAME_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      tmr        <= tmr_next;
      idx        <= idx_next;
      shreg      <= shreg_next;
      bit_q      <= bit_next;
      en_q       <= en_next;
      underrun_q <= slot_underrun;
      if (len_latch) begin
        len_q    <= bus.frame_len;
        byte_cnt <= '0;
        req_cnt  <= '0;
        buf_full <= 1'b0;
      end else begin
        if (pay_load) byte_cnt <= byte_cnt + 8'd1;
        req_cnt <= req_cnt + {7'b0, accept} + {7'b0, slot_underrun};
        // A byte accepted in a boundary cycle refills the buffer just emptied.
        if (accept) begin
          buf_q    <= bus.byte_in;
          buf_full <= 1'b1;
        end else if (pay_load) begin
          buf_full <= 1'b0;
        end
      end
`ifdef BPSK_FRAME_CRC_EN
      if (state == S_SYNC && state_next == S_LEN) crc_q <= crc8_byte(8'h00, len_q);
      else if (pay_load)                          crc_q <= crc8_byte(crc_q, pay_byte);
`endif
    end
  end

  assign bus.byte_ready   = byte_ready_c;
  assign bus.bit_data_out = bit_q;
  assign bus.bit_data_en  = en_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_c;
  assign bus.underrun     = underrun_q;

endmodule
